// File: rtl/cache_refill_ctrl_if.sv
// Bus bundle for cache_refill_ctrl: core data port, main-memory port and
// cache refill port. The controller connects through the master modport.
interface cache_refill_ctrl_if #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned ADDR      = 10,
    parameter int unsigned WORDS     = 4
);
    // Core side
    logic                       memRd;
    logic                       memWr;
    logic [ADDR-1:0]            addr;
    logic [MEM_WIDTH-1:0]       w_data;
    logic                       hit;
    logic                       stall;
    // Main-memory side
    logic                       mem_rd;
    logic                       mem_wr;
    logic [ADDR-1:0]            mem_addr;
    logic [MEM_WIDTH-1:0]       mem_wdata;
    logic [MEM_WIDTH-1:0]       mem_rdata;
    // Cache array refill side
    logic                       refill_we;
    logic [ADDR-1:0]            refill_addr;
    logic [MEM_WIDTH*WORDS-1:0] refill_line;
    logic                       fwd_valid;
    logic [MEM_WIDTH-1:0]       fwd_data;

    modport master (
        input  memRd, memWr, addr, w_data, hit, mem_rdata,
        output stall, mem_rd, mem_wr, mem_addr, mem_wdata,
        output refill_we, refill_addr, refill_line, fwd_valid, fwd_data
    );

    modport slave (
        output memRd, memWr, addr, w_data, hit, mem_rdata,
        input  stall, mem_rd, mem_wr, mem_addr, mem_wdata,
        input  refill_we, refill_addr, refill_line, fwd_valid, fwd_data
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Read-miss refill and write-through store controller.
// A read miss stalls the core, fetches the block one word per cycle, assembles
// the line and writes it into the cache array in a single FILL cycle. Stores
// are forwarded to main memory (write-through, no write-allocate).
// Optional feature macro: CACHE_CRIT_WORD_FIRST_EN (critical word first fetch
// order plus a one-cycle forward of the critical word).
module cache_refill_ctrl #(
    parameter int unsigned MEM_WIDTH = 32,
    parameter int unsigned ADDR      = 10,
    parameter int unsigned WORDS     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_ctrl_if.master  bus
);
    localparam int unsigned OFFW  = $clog2(WORDS);
    localparam int unsigned BLKW  = OFFW + 2;
    localparam int unsigned LINEW = MEM_WIDTH * WORDS;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] LAST  = 3'd3;
    localparam logic [2:0] FILL  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [ADDR-1:0]      base_q, base_d;
    logic [ADDR-1:0]      wr_addr_q, wr_addr_d;
    logic [MEM_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [OFFW-1:0]      start_q, start_d;
    logic [OFFW-1:0]      cnt_q, cnt_d;
    logic [OFFW-1:0]      prev_idx_q, prev_idx_d;
    logic [LINEW-1:0]     line_q, line_d;
    logic [OFFW-1:0]      cur_idx;
    logic                 capture;

    // Byte-within-word bits never matter to this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[1:0];

    // Word issued this cycle; width of OFFW gives the modulo-WORDS wrap.
    assign cur_idx = start_q + cnt_q;

    // Read data arrives one cycle after its strobe, so capture lags issue.
    assign capture = ((state_q == FETCH) && (cnt_q != '0)) || (state_q == LAST);

    // Next-state, request latching and line assembly.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        prev_idx_d = prev_idx_q;
        line_d     = line_q;
        case (state_q)
            IDLE: begin
                // A store takes priority over a simultaneous load.
                if (bus.memWr) begin
                    state_d   = WRITE;
                    wr_addr_d = {bus.addr[ADDR-1:2], 2'b00};
                    wr_data_d = bus.w_data;
                end else if (bus.memRd && !bus.hit) begin
                    state_d = FETCH;
                    base_d  = {bus.addr[ADDR-1:BLKW], {BLKW{1'b0}}};
                    cnt_d   = '0;
                    line_d  = '0;
`ifdef CACHE_CRIT_WORD_FIRST_EN
                    start_d = bus.addr[BLKW-1:2];
`else
                    start_d = '0;
`endif
                end
            end
            WRITE: state_d = IDLE;
            FETCH: begin
                cnt_d      = cnt_q + 1'b1;
                prev_idx_d = cur_idx;
                if (cnt_q == OFFW'(WORDS - 1)) begin
                    state_d = LAST;
                end
            end
            LAST:    state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (capture) begin
            for (int k = 0; k < WORDS; k++) begin
                if (prev_idx_q == OFFW'(k)) begin
                    line_d[k*MEM_WIDTH +: MEM_WIDTH] = bus.mem_rdata;
                end
            end
        end
    end

    // State registers; reset aborts any refill in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            start_q    <= '0;
            cnt_q      <= '0;
            prev_idx_q <= '0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            prev_idx_q <= prev_idx_d;
            line_q     <= line_d;
        end
    end

    // Output decode; memory strobes depend only on registered state.
    always_comb begin
        bus.stall       = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.refill_we   = 1'b0;
        bus.refill_addr = '0;
        bus.refill_line = '0;
        case (state_q)
            IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                bus.stall = !rst && (bus.memWr || (bus.memRd && !bus.hit));
            end
            WRITE: begin
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = wr_addr_q;
                bus.mem_wdata = wr_data_q;
            end
            FETCH: begin
                bus.stall    = 1'b1;
                bus.mem_rd   = 1'b1;
                bus.mem_addr = base_q | ADDR'({cur_idx, 2'b00});
            end
            LAST: bus.stall = 1'b1;
            FILL: begin
                bus.stall       = 1'b1;
                bus.refill_we   = 1'b1;
                bus.refill_addr = base_q;
                bus.refill_line = line_q;
            end
            default: bus.stall = 1'b0;
        endcase
    end

    // Critical-word forward: the first word issued is captured in FETCH cnt 1.
    always_comb begin
`ifdef CACHE_CRIT_WORD_FIRST_EN
        bus.fwd_valid = (state_q == FETCH) && (cnt_q == OFFW'(1));
        bus.fwd_data  = bus.fwd_valid ? bus.mem_rdata : '0;
`else
        bus.fwd_valid = 1'b0;
        bus.fwd_data  = '0;
`endif
    end
endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss and write-through controller between the core's data port and the main data memory inside the cache subsystem. It stalls the core on a read miss, fetches the 16-byte block word-by-word from main memory, assembles the 128-bit line and writes it into the cache array in one cycle. It also forwards every store to main memory, using a write-through, no-write-allocate policy.

## Interface
- MEM_WIDTH, 32: main-memory word width in bits.
- ADDR, 10: byte-address width.
- WORDS, 4: words per cache block; must be a power of two. The line is MEM_WIDTH*WORDS bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- memRd  in  1  core load request; held until stall is low at a clock edge.
- memWr  in  1  core store request; held like memRd.
- addr  in  ADDR  core byte address; bits [1:0] are ignored.
- w_data  in  MEM_WIDTH  store data.
- hit  in  1  tag-match result from the cache array for addr.
- stall  out  1  freezes the core PC and pipeline while high.
- mem_rd  out  1  main-memory read strobe.
- mem_wr  out  1  main-memory write strobe.
- mem_addr  out  ADDR  word-aligned byte address to main memory.
- mem_wdata  out  MEM_WIDTH  main-memory write data.
- mem_rdata  in  MEM_WIDTH  main-memory read data, valid one cycle after mem_rd.
- refill_we  out  1  one-cycle pulse that writes refill_line into the cache.
- refill_addr  out  ADDR  block-aligned address of the refilled line (low log2(WORDS)+2 bits are zero).
- refill_line  out  MEM_WIDTH*WORDS  assembled line; word k occupies bits [32k+31:32k].
- fwd_valid  out  1  critical-word forward strobe.
- fwd_data  out  MEM_WIDTH  critical-word forward data.

## Operation
- States: IDLE, WRITE, FETCH, LAST, FILL.
- IDLE:
  - memWr → stall=1 combinationally; next state WRITE; latch addr and w_data.
  - Else memRd & ~hit → stall=1; next state FETCH; latch the block base and the requested word index; cnt=0.
  - Else stall=0.
  - memWr and memRd together: the write wins and the read is ignored.
- WRITE: mem_wr=1 with the latched address and data; stall=0, so the store retires at this edge; next state IDLE. A cache update on hit is done by the cache array itself, not by this block.
- FETCH:
  - mem_rd=1; mem_addr = base | (word index << 2); cnt increments each cycle.
  - From the second FETCH cycle onward, mem_rdata is written into the line slot of the word issued in the previous cycle.
  - After WORDS issues, next state LAST.
- LAST: capture the final word; no strobe; next state FILL.
- FILL: refill_we=1, refill_addr=base, refill_line complete; next state IDLE, where hit is now 1 and the load retires.
- Word order without the macro: 0, 1, …, WORDS-1. Index arithmetic is modulo WORDS.
- stall is 1 in FETCH, LAST and FILL.

## Timing
- Reset values: state IDLE, every output 0, line buffer 0, cnt 0.
- Reset asserted mid-refill aborts the refill; no partial line is ever written (refill_we stays 0).
- mem_rd, mem_wr, mem_addr and mem_wdata are registered-state decodes and are glitch-free within a cycle.
- Store latency: 1 stall cycle; the store retires in the second cycle.
- Read-miss latency (WORDS=4): 1 IDLE + 4 FETCH + 1 LAST + 1 FILL = 7 stall cycles; the load retires in cycle 8.
- Read hit: 0 stall cycles.
- A new request is sampled only in IDLE. Back-to-back misses each pay the full latency.

## Configuration
- CACHE_CRIT_WORD_FIRST_EN defined:
  - FETCH order starts at addr[3:2] and wraps, e.g. 2, 3, 0, 1.
  - fwd_valid pulses for one cycle with fwd_data = critical word, in the cycle that captures it (the second FETCH cycle).
  - Total latency is unchanged.
- Undefined: linear order 0..WORDS-1; fwd_valid and fwd_data are tied to 0.

## Test plan
- Read miss at addr 0x048, memory words 0x040..0x04C = 0xA0, 0xA1, 0xA2, 0xA3:
  - mem_addr sequence 0x040, 0x044, 0x048, 0x04C.
  - refill_we pulses in the 7th stall cycle with refill_line = {A3, A2, A1, A0} and refill_addr = 0x040.
  - stall low in cycle 8.
- Store of 0xDEADBEEF to 0x010: stall high for 1 cycle; mem_wr=1 with mem_addr=0x010 and mem_wdata=0xDEADBEEF in cycle 2; no refill.
- Read with hit=1: stall is never asserted and mem_rd stays 0.
- rst pulse during the third FETCH cycle: all outputs 0 immediately; refill_we never pulses; the next miss restarts from word 0.
- memRd and memWr asserted together at 0x3F0: treated as a store only; no FETCH is entered.
- With CACHE_CRIT_WORD_FIRST_EN, miss at 0x3F8:
  - mem_addr sequence 0x3F8, 0x3FC, 0x3F0, 0x3F4 (top-of-memory wrap).
  - fwd_valid pulses once with the word at 0x3F8.
  - refill_line is identical to the linear-order result.
